// File: rtl/boot_loader_uart_pkg.sv
// Shared types and constants for the UART boot loader front end.
// Optional even-parity framing is enabled with BOOT_LOADER_PARITY_EN.
package boot_loader_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_WRITE  = 3'd5
    } rx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Each received byte is {address nibble, data nibble}.
    localparam int DATA_NIB_LSB = 0;
    localparam int ADDR_NIB_LSB = 4;

    function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] d,
                                             input logic                      p);
        return (^d) ^ p;
    endfunction

endpackage

// File: rtl/boot_loader_uart_if.sv
// CPU boot-loader write port; the loader is the master, the CPU the slave.
// No optional features here (BOOT_LOADER_PARITY_EN does not affect this file).
interface boot_loader_uart_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              bl_programm;
    logic [ADDR_W-1:0] bl_address;
    logic [DATA_W-1:0] bl_data;
    logic              bl_write_en_mem;

    modport master (output bl_programm, output bl_address, output bl_data, output bl_write_en_mem);
    modport slave  (input  bl_programm, input  bl_address, input  bl_data, input  bl_write_en_mem);
endinterface

// File: rtl/boot_loader_uart_rx.sv
// UART receive engine: synchronizer, bit timing, shift register and framing FSM.
// With BOOT_LOADER_PARITY_EN an even-parity bit is expected before the stop bit.
module uart_rx_bit
    import boot_loader_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      en_i,
    input  logic                      rx_i,
    output logic                      byte_valid_o,
    output logic                      frame_err_o,
    output logic [UART_DATA_BITS-1:0] byte_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int                BIT_W    = $clog2(UART_DATA_BITS);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    rx_state_e                 state_q, state_d;
    logic [1:0]                sync_q, sync_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      rx_s;
    logic                      stop_ok;
    logic                      cnt_full, cnt_half;

    assign sync_d   = {sync_q[0], rx_i};
    assign rx_s     = sync_q[1];
    assign cnt_full = (cnt_q == CNT_FULL);
    assign cnt_half = (cnt_q == CNT_HALF);
    assign byte_o   = shift_q;

`ifdef BOOT_LOADER_PARITY_EN
    logic par_err_q, par_err_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) par_err_q <= 1'b0;
        else         par_err_q <= par_err_d;
    end

    // A bad parity bit still lets the stop bit be consumed, but blocks the write.
    assign stop_ok = rx_s & ~par_err_q;
`else
    assign stop_ok = rx_s;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            sync_q  <= {2{UART_IDLE_LEVEL}};
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (rx_s != UART_IDLE_LEVEL) state_d = ST_START;
                ST_START:  if (cnt_half) state_d = rx_s ? ST_IDLE : ST_DATA;
`ifdef BOOT_LOADER_PARITY_EN
                ST_DATA:   if (cnt_full && bit_q == BIT_LAST) state_d = ST_PARITY;
                ST_PARITY: if (cnt_full) state_d = ST_STOP;
`else
                ST_DATA:   if (cnt_full && bit_q == BIT_LAST) state_d = ST_STOP;
`endif
                ST_STOP:   if (cnt_full) state_d = stop_ok ? ST_WRITE : ST_IDLE;
                ST_WRITE:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
`ifdef BOOT_LOADER_PARITY_EN
        par_err_d    = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            ST_START: if (cnt_half) cnt_d = '0;
            ST_DATA: if (cnt_full) begin
                cnt_d   = '0;
                bit_d   = bit_q + 1'b1;
                shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
            end
`ifdef BOOT_LOADER_PARITY_EN
            ST_PARITY: if (cnt_full) begin
                cnt_d     = '0;
                par_err_d = even_parity_err(shift_q, rx_s);
            end
`endif
            ST_STOP: if (cnt_full) begin
                cnt_d        = '0;
                byte_valid_o = stop_ok;
                frame_err_o  = ~stop_ok;
            end
            default: cnt_d = '0;
        endcase
        // Leaving programming mode aborts silently.
        if (!en_i) begin
            byte_valid_o = 1'b0;
            frame_err_o  = 1'b0;
        end
    end

endmodule

// File: rtl/boot_loader_uart.sv
// Boot loader top: session control, memory write strobe and write counter.
// Build with BOOT_LOADER_PARITY_EN for 8E1 framing; default is 8N1.
module boot_loader_uart
    import boot_loader_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT         = 16,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          prog_mode_i,
    input  logic                          rx_i,
    boot_loader_uart_if.master            bl,
    output logic                          frame_error_o,
    output logic [MEMORY_ADDRESS_WIDTH:0] write_count_o
);

    localparam logic [MEMORY_ADDRESS_WIDTH:0] COUNT_MAX =
        (MEMORY_ADDRESS_WIDTH + 1)'(MEMORY_REGISTERS);

    logic                            prog_q, prog_d;
    logic                            we_q, we_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [REGISTER_WIDTH-1:0]       data_q, data_d;
    logic                            ferr_q, ferr_d;
    logic [MEMORY_ADDRESS_WIDTH:0]   count_q, count_d;
    logic                            session_start;
    logic                            byte_valid, frame_err;
    logic [UART_DATA_BITS-1:0]       rx_byte;

    uart_rx_bit #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (prog_q),
        .rx_i         (rx_i),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err),
        .byte_o       (rx_byte)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prog_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            prog_q  <= prog_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        prog_d        = prog_mode_i;
        session_start = prog_mode_i & ~prog_q;
        // Gating with the pin keeps the strobe inside the registered program window.
        we_d          = byte_valid & prog_mode_i;
        addr_d        = we_d ? rx_byte[ADDR_NIB_LSB +: MEMORY_ADDRESS_WIDTH] : addr_q;
        data_d        = we_d ? rx_byte[DATA_NIB_LSB +: REGISTER_WIDTH] : data_q;
        ferr_d        = session_start ? 1'b0 : (ferr_q | frame_err);
        count_d       = count_q;
        if (session_start)
            count_d = '0;
        else if (we_d && count_q != COUNT_MAX)
            count_d = count_q + 1'b1;
    end

    assign bl.bl_programm     = prog_q;
    assign bl.bl_address      = addr_q;
    assign bl.bl_data         = data_q;
    assign bl.bl_write_en_mem = we_q;
    assign frame_error_o      = ferr_q;
    assign write_count_o      = count_q;

endmodule

// File: tb/tb_boot_loader_uart.sv
// Directed bench for the boot loader in its default 8N1 build.
module tb_boot_loader_uart;

    localparam int CPB = 16;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       prog_mode_i;
    logic       rx_i;
    logic       frame_error_o;
    logic [4:0] write_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;
    int bad_prog = 0;
    int doubles  = 0;
    int s0;
    logic [3:0] last_addr, last_data;
    logic       prev_we = 1'b0;

    boot_loader_uart_if #(.ADDR_W(4), .DATA_W(4)) bl ();

    boot_loader_uart #(
        .CLKS_PER_BIT(CPB), .REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4), .MEMORY_REGISTERS(16)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .prog_mode_i   (prog_mode_i),
        .rx_i          (rx_i),
        .bl            (bl),
        .frame_error_o (frame_error_o),
        .write_count_o (write_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Strobe monitor: records each write and flags illegal strobe shapes.
    always @(negedge clk_i) begin
        if (bl.bl_write_en_mem === 1'b1) begin
            strobes++;
            last_addr = bl.bl_address;
            last_data = bl.bl_data;
            if (bl.bl_programm !== 1'b1) bad_prog++;
            if (prev_we) doubles++;
        end
        prev_we = (bl.bl_write_en_mem === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk_i);
    endtask

    // Start, 8 data bits LSB first, stop; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = bits[i];
            repeat (CPB) @(negedge clk_i);
        end
    endtask

    initial begin
        reset_i = 1'b1; prog_mode_i = 1'b0; rx_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("rst_programm", bl.bl_programm, 0);
        check("rst_address",  bl.bl_address, 0);
        check("rst_data",     bl.bl_data, 0);
        check("rst_we",       bl.bl_write_en_mem, 0);
        check("rst_ferr",     frame_error_o, 0);
        check("rst_count",    write_count_o, 0);

        reset_i = 1'b0; prog_mode_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("prog_on", bl.bl_programm, 1);

        // Good frame 0x3A
        s0 = strobes;
        send_frame(8'h3A, 1'b1); idle(8);
        check("3a_strobes", strobes - s0, 1);
        check("3a_addr", last_addr, 4'h3);
        check("3a_data", last_data, 4'hA);
        check("3a_count", write_count_o, 1);
        check("3a_ferr", frame_error_o, 0);

        // Bad stop bit on 0x51
        s0 = strobes;
        send_frame(8'h51, 1'b0); idle(30);
        check("51_strobes", strobes - s0, 0);
        check("51_ferr", frame_error_o, 1);
        check("51_addr_hold", bl.bl_address, 4'h3);
        check("51_count", write_count_o, 1);
        prog_mode_i = 1'b0; idle(4);
        check("ferr_sticky", frame_error_o, 1);
        check("prog_off", bl.bl_programm, 0);
        prog_mode_i = 1'b1; idle(3);
        check("sess_ferr_clr", frame_error_o, 0);
        check("sess_count_clr", write_count_o, 0);

        // Short glitch on rx
        s0 = strobes;
        rx_i = 1'b0; repeat (4) @(negedge clk_i);
        idle(40);
        check("glitch_strobes", strobes - s0, 0);
        check("glitch_ferr", frame_error_o, 0);

        // Drop prog_mode after 3 data bits of 0xFF
        s0 = strobes;
        rx_i = 1'b0; repeat (CPB) @(negedge clk_i);
        rx_i = 1'b1; repeat (3 * CPB) @(negedge clk_i);
        prog_mode_i = 1'b0; idle(200);
        check("abort_strobes", strobes - s0, 0);
        check("abort_ferr", frame_error_o, 0);
        prog_mode_i = 1'b1; idle(3);
        send_frame(8'h20, 1'b1); idle(8);
        check("20_strobes", strobes - s0, 1);
        check("20_addr", last_addr, 4'h2);
        check("20_data", last_data, 4'h0);
        check("20_count", write_count_o, 1);

        // Back-to-back burst, counter saturation
        prog_mode_i = 1'b0; idle(2); prog_mode_i = 1'b1; idle(3);
        s0 = strobes;
        for (int i = 0; i < 16; i++) send_frame(8'(i << 4), 1'b1);
        idle(4);
        check("burst16_strobes", strobes - s0, 16);
        check("burst16_count", write_count_o, 16);
        check("burst16_addr", last_addr, 4'hF);
        send_frame(8'h0F, 1'b1); idle(8);
        check("burst17_strobes", strobes - s0, 17);
        check("burst17_count", write_count_o, 16);
        check("burst17_addr", last_addr, 4'h0);
        check("burst17_data", last_data, 4'hF);

        // Reset mid-frame
        rx_i = 1'b0; repeat (40) @(negedge clk_i);
        reset_i = 1'b1; rx_i = 1'b1; repeat (2) @(negedge clk_i);
        check("mrst_count", write_count_o, 0);
        check("mrst_address", bl.bl_address, 0);
        check("mrst_data", bl.bl_data, 0);
        check("mrst_programm", bl.bl_programm, 0);
        reset_i = 1'b0; idle(200);
        s0 = strobes;
        send_frame(8'hC5, 1'b1); idle(8);
        check("c5_strobes", strobes - s0, 1);
        check("c5_addr", last_addr, 4'hC);
        check("c5_data", last_data, 4'h5);
        check("c5_count", write_count_o, 1);

        check("strobe_without_prog", bad_prog, 0);
        check("strobe_width", doubles, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
